// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: FSM states, PS/2 command bytes, 100 MHz timing defaults and parity helper.
package ps2_host_tx_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_WAIT_DEV,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;
  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam int PS2_INHIBIT_CYCLES = 12_000;
  localparam int PS2_START_TIMEOUT  = 1_500_000;
  localparam int PS2_FRAME_TIMEOUT  = 200_000;
  localparam int PS2_MAX_RETRY      = 3;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte request handshake and completion status between a client and ps2_host_tx.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout_err;
  modport master (output tx_data, tx_valid, input tx_ready, busy, done, ack_err, timeout_err);
  modport slave  (input tx_data, tx_valid, output tx_ready, busy, done, ack_err, timeout_err);
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchroniser for the PS/2 pins plus falling-edge detect on the clock line.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic fall
);
  logic [1:0] clk_sr, data_sr;
  logic       clk_prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clk_sr   <= 2'b11;
      data_sr  <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sr   <= {clk_sr[0], clk_in};
      data_sr  <= {data_sr[0], data_in};
      clk_prev <= clk_sr[1];
    end
  assign clk_s  = clk_sr[1];
  assign data_s = data_sr[1];
  assign fall   = clk_prev & ~clk_sr[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter driving open-drain enables; PS2_TX_AUTO_RETRY_EN adds resend on NACK/timeout.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int START_TIMEOUT  = PS2_START_TIMEOUT,
  parameter int FRAME_TIMEOUT  = PS2_FRAME_TIMEOUT
`ifdef PS2_TX_AUTO_RETRY_EN
  , parameter int MAX_RETRY    = PS2_MAX_RETRY
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);
  localparam logic [20:0] INH_LIM   = 21'(INHIBIT_CYCLES - 1);
  localparam logic [20:0] START_LIM = 21'(START_TIMEOUT - 1);
  localparam logic [20:0] FRAME_LIM = 21'(FRAME_TIMEOUT - 1);
  state_t      state, state_d;
  logic [20:0] timer, timer_d;
  logic [3:0]  bit_cnt, bit_cnt_d;
  logic [7:0]  tx_byte, tx_byte_d;
  logic        par, par_d, clk_oe, clk_oe_d, data_oe, data_oe_d;
  logic        done, done_d, ack_err, ack_err_d, timeout_err, timeout_err_d;
  logic        clk_s, data_s, fall, to, fin;
`ifdef PS2_TX_AUTO_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry, retry_d;
`endif
  ps2_line_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_in (ps2_clk_i),
    .data_in(ps2_data_i),
    .clk_s  (clk_s),
    .data_s (data_s),
    .fall   (fall)
  );
  assign to  = (state == ST_WAIT_DEV && timer >= START_LIM) ||
               ((state == ST_SHIFT || state == ST_ACK || state == ST_WAIT_IDLE) && timer >= FRAME_LIM);
  assign fin = to || (state == ST_WAIT_IDLE && clk_s && data_s);
  always_comb begin
    state_d       = state;
    timer_d       = &timer ? timer : timer + 21'd1;
    bit_cnt_d     = bit_cnt;
    tx_byte_d     = tx_byte;
    par_d         = par;
    clk_oe_d      = clk_oe;
    data_oe_d     = data_oe;
    done_d        = 1'b0;
    ack_err_d     = ack_err;
    timeout_err_d = timeout_err;
`ifdef PS2_TX_AUTO_RETRY_EN
    retry_d       = retry;
`endif
    case (state)
      ST_IDLE: if (bus.tx_valid) begin
        state_d       = ST_INHIBIT;
        tx_byte_d     = bus.tx_data;
        par_d         = odd_parity(bus.tx_data);
        bit_cnt_d     = 4'd0;
        timer_d       = '0;
        clk_oe_d      = 1'b1;
        ack_err_d     = 1'b0;
        timeout_err_d = 1'b0;
`ifdef PS2_TX_AUTO_RETRY_EN
        retry_d       = '0;
`endif
      end
      ST_INHIBIT: if (timer == INH_LIM) begin
        state_d   = ST_RTS;
        data_oe_d = 1'b1;
      end
      ST_RTS: begin
        state_d  = ST_WAIT_DEV;
        clk_oe_d = 1'b0;
        timer_d  = '0;
      end
      ST_WAIT_DEV: if (fall) begin
        state_d   = ST_SHIFT;
        bit_cnt_d = 4'd1;
        data_oe_d = ~tx_byte[0];
        timer_d   = '0;
      end
      // bit_cnt holds the fall count so far: 1..7 -> next data bit, 8 -> parity, 9 -> stop
      ST_SHIFT: if (fall) begin
        bit_cnt_d = bit_cnt + 4'd1;
        data_oe_d = bit_cnt < 4'd8 ? ~tx_byte[bit_cnt[2:0]] : (bit_cnt == 4'd8 ? ~par : 1'b0);
        state_d   = bit_cnt == 4'd9 ? ST_ACK : ST_SHIFT;
      end
      ST_ACK: if (fall) begin
        bit_cnt_d = bit_cnt + 4'd1;
        ack_err_d = data_s;
        state_d   = ST_WAIT_IDLE;
      end
      default: ;
    endcase
    if (fin) begin
      state_d       = ST_IDLE;
      clk_oe_d      = 1'b0;
      data_oe_d     = 1'b0;
      done_d        = 1'b1;
      timeout_err_d = to;
      ack_err_d     = ~to & ack_err;
`ifdef PS2_TX_AUTO_RETRY_EN
      if ((to || ack_err) && int'(retry) < MAX_RETRY) begin
        state_d       = ST_INHIBIT;
        retry_d       = retry + 1'b1;
        clk_oe_d      = 1'b1;
        done_d        = 1'b0;
        timer_d       = '0;
        bit_cnt_d     = 4'd0;
        ack_err_d     = 1'b0;
        timeout_err_d = 1'b0;
      end
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= ST_IDLE;
      timer       <= '0;
      bit_cnt     <= '0;
      tx_byte     <= '0;
      par         <= 1'b0;
      clk_oe      <= 1'b0;
      data_oe     <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
`ifdef PS2_TX_AUTO_RETRY_EN
      retry       <= '0;
`endif
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      bit_cnt     <= bit_cnt_d;
      tx_byte     <= tx_byte_d;
      par         <= par_d;
      clk_oe      <= clk_oe_d;
      data_oe     <= data_oe_d;
      done        <= done_d;
      ack_err     <= ack_err_d;
      timeout_err <= timeout_err_d;
`ifdef PS2_TX_AUTO_RETRY_EN
      retry       <= retry_d;
`endif
    end
  assign bus.tx_ready    = state == ST_IDLE;
  assign bus.busy        = state != ST_IDLE;
  assign bus.done        = done;
  assign bus.ack_err     = ack_err;
  assign bus.timeout_err = timeout_err;
  assign ps2_clk_oe      = clk_oe;
  assign ps2_data_oe     = data_oe;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: table, random and corner-case checks of ps2_host_tx against a clocking PS/2 device model.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;
`ifdef PS2_TX_AUTO_RETRY_EN
  localparam int NACK_FRAMES = 4;
`else
  localparam int NACK_FRAMES = 1;
`endif
  logic clk, rst_n, clk_oe, data_oe, ps2_clk_i, ps2_data_i;
  logic dev_clk_lo, dev_data_lo, dev_mute, nack_mode;
  int   fall_cnt, tests, fails;
  logic [10:0] frames[$];
  ps2_host_tx_if bus ();
  ps2_host_tx #(.INHIBIT_CYCLES(20), .START_TIMEOUT(500), .FRAME_TIMEOUT(2000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (clk_oe),
    .ps2_data_oe(data_oe)
  );
  assign ps2_clk_i  = ~(clk_oe | dev_clk_lo);
  assign ps2_data_i = ~(data_oe | dev_data_lo);
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  // Frame as the device should see it: start, d0..d7, odd parity, stop
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    f[9]  = (ones % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction
  task automatic dev_wait(input int n, inout bit ab);
    for (int c = 0; c < n && !ab; c++) begin
      @(negedge clk);
      if (!rst_n) ab = 1'b1;
    end
  endtask
  task automatic serve();
    logic [10:0] f;
    bit ab;
    ab = 1'b0;
    f = '0;
    fall_cnt = 0;
    dev_wait(10, ab);
    f[0] = ps2_data_i;
    for (int k = 1; k <= 11 && !ab; k++) begin
      if (k == 11 && !nack_mode) begin
        dev_data_lo = 1'b1;
        dev_wait(5, ab);
      end
      dev_clk_lo = 1'b1;
      fall_cnt = k;
      dev_wait(40, ab);
      dev_clk_lo = 1'b0;
      if (k <= 10) begin
        f[k] = ps2_data_i;
        dev_wait(40, ab);
      end
    end
    dev_clk_lo = 1'b0;
    dev_data_lo = 1'b0;
    if (!ab) frames.push_back(f);
  endtask
  initial begin
    dev_clk_lo = 1'b0;
    dev_data_lo = 1'b0;
    fall_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst_n && !dev_mute && ps2_clk_i && !ps2_data_i) serve();
    end
  end
  task automatic start_tx(input logic [7:0] d);
    for (int i = 0; i < 5000 && !bus.tx_ready; i++) @(negedge clk);
    @(negedge clk);
    bus.tx_data = d;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    #1 bus.tx_valid = 1'b0;
  endtask
  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10000 && !ok; i++) begin
      @(negedge clk);
      ok = bus.done;
    end
    chk("done_seen", 32'(ok), 1);
  endtask
  task automatic check_frames(input logic [7:0] d, input int n);
    chk("frame_count", frames.size(), n);
    foreach (frames[i]) chk("frame_bits", 32'(frames[i]), 32'(exp_frame(d)));
  endtask
  task automatic run_vec(input logic [7:0] d, input bit nk, input bit exp_err, input int nf);
    frames.delete();
    nack_mode = nk;
    start_tx(d);
    wait_done();
    chk("ack_err", 32'(bus.ack_err), 32'(exp_err));
    chk("timeout_err", 32'(bus.timeout_err), 0);
    check_frames(d, nf);
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 0);
  endtask
  typedef struct {
    logic [7:0] data;
    bit         nack;
    bit         exp_err;
    int         nframes;
  } vec_t;
  vec_t vecs[5];
  int n;
  logic [7:0] rd;
  bit rn;
  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    dev_mute = 1'b0;
    nack_mode = 1'b0;
    bus.tx_data = '0;
    bus.tx_valid = 1'b0;
    vecs[0] = '{PS2_CMD_SET_LED, 1'b0, 1'b0, 1};
    vecs[1] = '{PS2_CMD_ENABLE,  1'b0, 1'b0, 1};
    vecs[2] = '{PS2_CMD_RESET,   1'b1, 1'b1, NACK_FRAMES};
    vecs[3] = '{8'h00,           1'b0, 1'b0, 1};
    vecs[4] = '{8'hA5,           1'b0, 1'b0, 1};
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", 32'(bus.tx_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_clk_oe", 32'(clk_oe), 0);
    chk("rst_data_oe", 32'(data_oe), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_ack_err", 32'(bus.ack_err), 0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    foreach (vecs[i]) run_vec(vecs[i].data, vecs[i].nack, vecs[i].exp_err, vecs[i].nframes);
    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom);
      rn = 1'($urandom_range(0, 1));
      run_vec(rd, rn, rn, rn ? NACK_FRAMES : 1);
    end
    nack_mode = 1'b0;
    frames.delete();
    for (int i = 0; i < 5000 && !bus.tx_ready; i++) @(negedge clk);
    @(negedge clk);
    bus.tx_data = PS2_CMD_ENABLE;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    #1 bus.tx_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (clk_oe && !data_oe && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("inhibit_len", n, 20);
    chk("rts_clk_oe", 32'(clk_oe), 1);
    chk("rts_data_oe", 32'(data_oe), 1);
    wait_done();
    chk("f4_ack_err", 32'(bus.ack_err), 0);
    check_frames(PS2_CMD_ENABLE, 1);
    dev_mute = 1'b1;
    frames.delete();
    start_tx(PS2_CMD_SET_LED);
    for (int i = 0; i < 200 && !data_oe; i++) @(negedge clk);
    chk("to_rts_seen", 32'(data_oe), 1);
    for (int i = 0; i < 20 && clk_oe; i++) @(negedge clk);
    n = 0;
    while (!bus.done && n < 5000) begin
      @(negedge clk);
      n++;
    end
`ifndef PS2_TX_AUTO_RETRY_EN
    chk("to_latency", n, 500);
`endif
    chk("to_done", 32'(bus.done), 1);
    chk("to_timeout_err", 32'(bus.timeout_err), 1);
    chk("to_ack_err", 32'(bus.ack_err), 0);
    chk("to_clk_oe", 32'(clk_oe), 0);
    chk("to_data_oe", 32'(data_oe), 0);
    chk("to_frames", frames.size(), 0);
    dev_mute = 1'b0;
    frames.delete();
    start_tx(PS2_CMD_SET_LED);
    n = 0;
    while (fall_cnt != 5 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("fall5_seen", fall_cnt, 5);
    for (int i = 0; i < 20 && !data_oe; i++) @(negedge clk);
    chk("pre_rst_data_oe", 32'(data_oe), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_clk_oe", 32'(clk_oe), 0);
    chk("rst_mid_data_oe", 32'(data_oe), 0);
    chk("rst_mid_tx_ready", 32'(bus.tx_ready), 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("rst_aborted_frames", frames.size(), 0);
    run_vec(PS2_CMD_SET_LED, 1'b0, 1'b0, 1);
    frames.delete();
    start_tx(PS2_CMD_SET_LED);
    n = 0;
    while (fall_cnt != 3 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("shift_busy", 32'(bus.busy), 1);
    chk("shift_tx_ready", 32'(bus.tx_ready), 0);
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    wait_done();
    chk("shift_ack_err", 32'(bus.ack_err), 0);
    check_frames(PS2_CMD_SET_LED, 1);
    repeat (300) @(negedge clk);
    chk("no_queued_frame", frames.size(), 1);
    chk("idle_busy", 32'(bus.busy), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
